// File: rtl/lsu_memory_if.sv
// Load/store request and response bundle between a requester and lsu_memory.
interface lsu_memory_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_error;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/lsu_memory.sv
// Byte-addressable data RAM behind the load/store path: LB/LH/LW/LBU/LHU and
// SB/SH/SW with byte enables and sign/zero extension. Each request walks the
// FSM IDLE -> ACC0 [-> ACC1] -> RESP.
// Build option: define LSU_MISALIGN_EN to split word-crossing half/word
// accesses over ACC0/ACC1; without it those accesses (and any half with
// addr[0]=1 or word with addr[1:0]!=0) complete with rsp_error.
module lsu_memory #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic        clock,
    input  logic        reset_n,
    lsu_memory_if.slave bus
);
    localparam int unsigned WORD_W = ADDR_W - 2;
    localparam int unsigned DEPTH  = 1 << WORD_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef struct packed {
        logic              write;
        logic [1:0]        size;
        logic              uns;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
    } req_t;

    state_t            state;
    state_t            state_next;
    req_t              req_q;
    logic [31:0]       mem [DEPTH];

    logic              transfer;
    logic [1:0]        offset;
    logic [3:0]        lane_mask;
    logic [3:0]        lane_lo;
    logic              acc_error;
    logic [WORD_W-1:0] word0;
    logic [WORD_W-1:0] word_sel;
    logic [3:0]        byte_en;
    logic [31:0]       cur_word;
    logic [31:0]       rd_rot;
    logic [31:0]       wr_rot;
    logic [31:0]       load_data;
    logic [31:0]       ext_data;
    logic              mem_we;
    logic [31:0]       rdata_next;
    logic              error_next;
`ifdef LSU_MISALIGN_EN
    logic [7:0]        byte_pos;
    logic              split;
    logic              in_acc1;
    logic [31:0]       collect_q;
`endif

    assign transfer = bus.req_valid && bus.req_ready;

    // Decode the registered request: lane mask, alignment error, byte placement.
    always_comb begin
        offset    = req_q.addr[1:0];
        word0     = req_q.addr[ADDR_W-1:2];
        lane_mask = 4'b0000;
        case (req_q.size)
            2'b00:   lane_mask = 4'b0001;
            2'b01:   lane_mask = 4'b0011;
            2'b10:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
        // Lanes that live in the first word; the rest spill into the next word.
        lane_lo = 4'b1111 >> offset;
`ifdef LSU_MISALIGN_EN
        byte_pos  = 8'({4'b0000, lane_mask} << offset);
        split     = |byte_pos[7:4];
        in_acc1   = (state == ACC1);
        acc_error = (req_q.size == 2'b11);
        word_sel  = in_acc1 ? WORD_W'(word0 + 1'b1) : word0;
        byte_en   = in_acc1 ? byte_pos[7:4] : byte_pos[3:0];
`else
        acc_error = (req_q.size == 2'b11)
                 || ((req_q.size == 2'b01) && offset[0])
                 || ((req_q.size == 2'b10) && (offset != 2'b00));
        word_sel  = word0;
        byte_en   = 4'({4'b0000, lane_mask} << offset);
`endif
    end

    // Rotate store data so lane k lands on word byte (offset + k) mod 4,
    // and rotate the read word so word byte (offset + k) mod 4 lands on lane k.
    always_comb begin
        cur_word = mem[word_sel];
        case (offset)
            2'd0: begin
                wr_rot = req_q.wdata;
                rd_rot = cur_word;
            end
            2'd1: begin
                wr_rot = {req_q.wdata[23:0], req_q.wdata[31:24]};
                rd_rot = {cur_word[7:0], cur_word[31:8]};
            end
            2'd2: begin
                wr_rot = {req_q.wdata[15:0], req_q.wdata[31:16]};
                rd_rot = {cur_word[15:0], cur_word[31:16]};
            end
            default: begin
                wr_rot = {req_q.wdata[7:0], req_q.wdata[31:8]};
                rd_rot = {cur_word[23:0], cur_word[31:24]};
            end
        endcase
    end

    // Assemble load lanes: first-word lanes from ACC0, second-word lanes from ACC1.
    always_comb begin
        load_data = '0;
        for (int k = 0; k < 4; k++) begin
`ifdef LSU_MISALIGN_EN
            if (lane_lo[k]) begin
                load_data[8*k +: 8] = in_acc1 ? collect_q[8*k +: 8] : rd_rot[8*k +: 8];
            end else begin
                load_data[8*k +: 8] = in_acc1 ? rd_rot[8*k +: 8] : 8'h00;
            end
`else
            load_data[8*k +: 8] = lane_lo[k] ? rd_rot[8*k +: 8] : 8'h00;
`endif
        end
    end

    // Sign or zero extension by access size; words pass through.
    always_comb begin
        case (req_q.size)
            2'b00:   ext_data = req_q.uns ? {24'h000000, load_data[7:0]}
                                          : {{24{load_data[7]}}, load_data[7:0]};
            2'b01:   ext_data = req_q.uns ? {16'h0000, load_data[15:0]}
                                          : {{16{load_data[15]}}, load_data[15:0]};
            default: ext_data = load_data;
        endcase
    end

    // Next-state, write strobe and next response values.
    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        rdata_next = '0;
        error_next = 1'b0;
        case (state)
            IDLE: begin
                if (transfer) begin
                    state_next = ACC0;
                end
            end
            ACC0: begin
                if (acc_error) begin
                    state_next = RESP;
                    error_next = 1'b1;
`ifdef LSU_MISALIGN_EN
                end else if (split) begin
                    state_next = ACC1;
                    mem_we     = req_q.write;
`endif
                end else begin
                    state_next = RESP;
                    mem_we     = req_q.write;
                    rdata_next = req_q.write ? 32'h0 : ext_data;
                end
            end
`ifdef LSU_MISALIGN_EN
            ACC1: begin
                state_next = RESP;
                mem_we     = req_q.write;
                rdata_next = req_q.write ? 32'h0 : ext_data;
            end
`endif
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, request capture and registered response outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_error <= 1'b0;
            req_q         <= '0;
        end else begin
            state         <= state_next;
            bus.req_ready <= (state_next == IDLE);
            bus.rsp_valid <= (state_next == RESP);
            bus.rsp_rdata <= rdata_next;
            bus.rsp_error <= error_next;
            if (transfer) begin
                req_q.write <= bus.req_write;
                req_q.size  <= bus.req_size;
                req_q.uns   <= bus.req_unsigned;
                req_q.addr  <= bus.req_addr;
                req_q.wdata <= bus.req_wdata;
            end
        end
    end

`ifdef LSU_MISALIGN_EN
    // Hold first-word load lanes across the ACC1 cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            collect_q <= '0;
        end else if (state == ACC0) begin
            collect_q <= load_data;
        end
    end
`endif

    // Byte-enabled write; the array itself is never reset and reset blocks writes.
    always_ff @(posedge clock) begin
        if (reset_n && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_sel][8*b +: 8] <= wr_rot[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_lsu_memory.sv
// Directed bench for lsu_memory: hand-computed loads/stores, latency,
// alignment errors, word wrap and reset abort.
module tb_lsu_memory;
    localparam int unsigned ADDR_W = 12;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    lsu_memory_if #(.ADDR_W(ADDR_W)) bus ();

    lsu_memory #(.ADDR_W(ADDR_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request: checks latency (cycles after transfer), error, data, and the idle cycle after.
    task automatic xfer(input string tag, input logic wr, input logic [1:0] size, input logic uns,
                        input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic exp_err, input logic [31:0] exp_data);
        int wait_cyc;
        int lat;
        @(negedge clock);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        wait_cyc = 0;
        while (bus.req_ready !== 1'b1 && wait_cyc < 16) begin
            @(negedge clock);
            wait_cyc++;
        end
        if (bus.req_ready !== 1'b1) begin
            check({tag, "/ready_timeout"}, 32'(bus.req_ready), 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 8) begin
            @(posedge clock);
            #1;
            lat++;
        end
        if (bus.rsp_valid !== 1'b1) begin
            check({tag, "/rsp_timeout"}, 32'(bus.rsp_valid), 32'd1);
            return;
        end
        check({tag, "/lat"},   32'(lat), 32'(exp_lat));
        check({tag, "/err"},   32'(bus.rsp_error), 32'(exp_err));
        check({tag, "/rdata"}, bus.rsp_rdata, exp_data);
        @(posedge clock);
        #1;
        check({tag, "/after_rdy_vld_err"},
              {29'd0, bus.req_ready, bus.rsp_valid, bus.rsp_error}, 32'b100);
        check({tag, "/after_rdata"}, bus.rsp_rdata, 32'h0);
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;

        repeat (3) @(posedge clock);
        #1;
        check("reset/ready", 32'(bus.req_ready), 32'd1);
        check("reset/valid", 32'(bus.rsp_valid), 32'd0);
        check("reset/rdata", bus.rsp_rdata, 32'h0);
        check("reset/error", 32'(bus.rsp_error), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Aligned word store/load and sub-word extraction.
        xfer("sw_10",  1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 2, 1'b0, 32'h0);
        xfer("lw_10",  1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        2, 1'b0, 32'hDEADBEEF);
        xfer("lb_13",  1'b0, 2'b00, 1'b0, 12'h013, 32'h0,        2, 1'b0, 32'hFFFFFFDE);
        xfer("lbu_13", 1'b0, 2'b00, 1'b1, 12'h013, 32'h0,        2, 1'b0, 32'h000000DE);
        xfer("lh_12",  1'b0, 2'b01, 1'b0, 12'h012, 32'h0,        2, 1'b0, 32'hFFFFDEAD);
        xfer("lhu_12", 1'b0, 2'b01, 1'b1, 12'h012, 32'h0,        2, 1'b0, 32'h0000DEAD);

        // Byte store touches only its lane.
        xfer("sb_11",  1'b1, 2'b00, 1'b0, 12'h011, 32'hAAAAAA55, 2, 1'b0, 32'h0);
        xfer("lw_10b", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        2, 1'b0, 32'hDEAD55EF);

        // Word-crossing load.
        xfer("sw_14",  1'b1, 2'b10, 1'b0, 12'h014, 32'h11223344, 2, 1'b0, 32'h0);
`ifdef LSU_MISALIGN_EN
        xfer("lw_12x", 1'b0, 2'b10, 1'b0, 12'h012, 32'h0,        3, 1'b0, 32'h3344DEAD);
        xfer("lh_11",  1'b0, 2'b01, 1'b0, 12'h011, 32'h0,        2, 1'b0, 32'hFFFFAD55);
        xfer("lh_13x", 1'b0, 2'b01, 1'b1, 12'h013, 32'h0,        3, 1'b0, 32'h000044DE);
`else
        xfer("lw_12x", 1'b0, 2'b10, 1'b0, 12'h012, 32'h0,        2, 1'b1, 32'h0);
        xfer("lh_11",  1'b0, 2'b01, 1'b0, 12'h011, 32'h0,        2, 1'b1, 32'h0);
        xfer("sh_11",  1'b1, 2'b01, 1'b0, 12'h011, 32'hFFFFFFFF, 2, 1'b1, 32'h0);
        xfer("sw_12",  1'b1, 2'b10, 1'b0, 12'h012, 32'hFFFFFFFF, 2, 1'b1, 32'h0);
        xfer("lw_10c", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        2, 1'b0, 32'hDEAD55EF);
        xfer("lw_14c", 1'b0, 2'b10, 1'b0, 12'h014, 32'h0,        2, 1'b0, 32'h11223344);
`endif

        // Reserved size: error, no write.
        xfer("s11_10", 1'b1, 2'b11, 1'b0, 12'h010, 32'hFFFFFFFF, 2, 1'b1, 32'h0);
        xfer("l11_10", 1'b0, 2'b11, 1'b0, 12'h010, 32'h0,        2, 1'b1, 32'h0);
        xfer("lw_10d", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        2, 1'b0, 32'hDEAD55EF);

        // Halfword store and sign/zero extension of halves.
        xfer("sw_18",  1'b1, 2'b10, 1'b0, 12'h018, 32'h00000000, 2, 1'b0, 32'h0);
        xfer("sh_18",  1'b1, 2'b01, 1'b0, 12'h018, 32'hCAFE8001, 2, 1'b0, 32'h0);
        xfer("lh_18",  1'b0, 2'b01, 1'b0, 12'h018, 32'h0,        2, 1'b0, 32'hFFFF8001);
        xfer("lhu_1a", 1'b0, 2'b01, 1'b1, 12'h01A, 32'h0,        2, 1'b0, 32'h00000000);
        xfer("lw_18",  1'b0, 2'b10, 1'b0, 12'h018, 32'h0,        2, 1'b0, 32'h00008001);

`ifdef LSU_MISALIGN_EN
        // Split store wrapping from the last word to word 0.
        xfer("sw_ffe",  1'b1, 2'b10, 1'b0, 12'hFFE, 32'hA1B2C3D4, 3, 1'b0, 32'h0);
        xfer("lhu_ffe", 1'b0, 2'b01, 1'b1, 12'hFFE, 32'h0,        2, 1'b0, 32'h0000C3D4);
        xfer("lhu_000", 1'b0, 2'b01, 1'b1, 12'h000, 32'h0,        2, 1'b0, 32'h0000A1B2);
`else
        xfer("sw_ffe",  1'b1, 2'b10, 1'b0, 12'hFFE, 32'hA1B2C3D4, 2, 1'b1, 32'h0);
`endif

        // Reset during ACC0 of a store: no write, no response.
        xfer("sw_20z", 1'b1, 2'b10, 1'b0, 12'h020, 32'h00000000, 2, 1'b0, 32'h0);
        @(negedge clock);
        bus.req_valid    = 1'b1;
        bus.req_write    = 1'b1;
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 12'h020;
        bus.req_wdata    = 32'h12345678;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        reset_n       = 1'b0;
        check("rst/acc0_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        check("rst/held_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clock);
        #1;
        check("rst/release_ready", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("rst/no_pulse", 32'(bus.rsp_valid), 32'd0);
            @(posedge clock);
            #1;
        end
        xfer("lw_20", 1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 2, 1'b0, 32'h00000000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
